// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_pkg                                                       |
// | Purpose  : Operation encoding and one-level mux helper for shift_pipe.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package shift_pkg;

  // Widest datapath the helper supports; callers zero-extend into it.
  localparam int c_shift_max_w = 128;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_SLA = 3'd3,
    OP_ROL = 3'd4,
    OP_ROR = 3'd5
  } shift_op_t;

  // One mux level: shift/rotate by 2**k when en is set. Only the low
  // 'width' bits are meaningful; bits above width are returned as zero.
  // Codes 6/7 fall into the default arm and pass the data through.
  function automatic logic [c_shift_max_w-1:0] shift_level(
    input logic [c_shift_max_w-1:0] data,
    input shift_op_t                op,
    input logic                     fill,
    input int unsigned              k,
    input logic                     en,
    input int unsigned              width
  );
    logic [c_shift_max_w-1:0] w_mask;
    logic [c_shift_max_w-1:0] w_res;
    int unsigned              w_s;
    w_s    = 32'd1 << k;
    w_mask = ~({c_shift_max_w{1'b1}} << width);
    w_res  = data;
    if (en) begin
      case (op)
        OP_SLL, OP_SLA: w_res = (data << w_s) & w_mask;
        OP_SRL:         w_res = data >> w_s;
        OP_SRA:         w_res = (data >> w_s) | (fill ? (w_mask & ~(w_mask >> w_s)) : '0);
        OP_ROL:         w_res = ((data << w_s) | (data >> (width - w_s))) & w_mask;
        OP_ROR:         w_res = ((data >> w_s) | (data << (width - w_s))) & w_mask;
        default:        w_res = data;
      endcase
    end
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_stage                                                     |
// | Purpose  : LEVELS combinational mux levels starting at FIRST_LEVEL,        |
// |            followed by the stage register bank (global enable).            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module shift_stage
  import shift_pkg::*;
#(
  parameter int N_bits      = 32,
  parameter int LEVELS      = 1,
  parameter int FIRST_LEVEL = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_i,
  input  logic                      valid_i,
  input  logic [N_bits-1:0]         data_i,
  input  logic [$clog2(N_bits)-1:0] amount_i,
  input  shift_op_t                 op_i,
  input  logic                      fill_i,
  output logic                      valid_o,
  output logic [N_bits-1:0]         data_o,
  output logic [$clog2(N_bits)-1:0] amount_o,
  output shift_op_t                 op_o,
  output logic                      fill_o,
  output logic                      zero_o
);

  logic [N_bits-1:0]         w_lvl [0:LEVELS];
  logic [N_bits-1:0]         data_d;
  logic                      zero_d;

  logic                      valid_q;
  logic [N_bits-1:0]         data_q;
  logic [$clog2(N_bits)-1:0] amount_q;
  shift_op_t                 op_q;
  logic                      fill_q;
  logic                      zero_q;

  assign w_lvl[0] = data_i;

  // A stage with LEVELS = 0 is a plain register slice.
  generate
    for (genvar i = 0; i < LEVELS; i++) begin : g_level
      assign w_lvl[i+1] = N_bits'(shift_level(c_shift_max_w'(w_lvl[i]), op_i, fill_i,
                                              FIRST_LEVEL + i, amount_i[FIRST_LEVEL + i],
                                              N_bits));
    end
  endgenerate

  assign data_d = w_lvl[LEVELS];
  assign zero_d = (data_d == '0);

  // Stage register bank; bubbles load too, so every stage moves in lockstep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      amount_q <= '0;
      op_q     <= OP_SLL;
      fill_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (en_i) begin
      valid_q  <= valid_i;
      data_q   <= data_d;
      amount_q <= amount_i;
      op_q     <= op_i;
      fill_q   <= fill_i;
      zero_q   <= zero_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign amount_o = amount_q;
  assign op_o     = op_q;
  assign fill_o   = fill_q;
  assign zero_o   = zero_q;

endmodule
`default_nettype wire

// File: rtl/shift_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_pipe                                                      |
// | Purpose  : Pipelined barrel shifter/rotator, STAGES register stages,       |
// |            valid/ready handshake with a single global advance enable.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module shift_pipe
  import shift_pkg::*;
#(
  parameter int N_bits = 32,
  parameter int STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_bits-1:0]         in_d,
  input  logic [$clog2(N_bits)-1:0] in_amount,
  input  shift_op_t                 in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_bits-1:0]         out_d,
  output logic                      out_zero
);

  localparam int c_levels = $clog2(N_bits);
  // Levels per stage, rounded up; trailing stages may get fewer (or none).
  localparam int c_lps    = (c_levels + STAGES - 1) / STAGES;

  logic                      w_advance;
  logic                      w_valid  [0:STAGES];
  logic [N_bits-1:0]         w_data   [0:STAGES];
  logic [$clog2(N_bits)-1:0] w_amount [0:STAGES];
  shift_op_t                 w_op     [0:STAGES];
  logic                      w_fill   [0:STAGES];
  logic                      w_zero   [0:STAGES-1];

  // Stage-0 inputs; the SRA fill bit is captured here and travels with the data.
  assign w_valid[0]  = in_valid;
  assign w_data[0]   = in_d;
  assign w_amount[0] = in_amount;
  assign w_op[0]     = in_op;
  assign w_fill[0]   = in_d[N_bits-1];

  generate
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int c_first = s * c_lps;
      localparam int c_nlev  = (c_first >= c_levels) ? 0 :
                               ((c_levels - c_first < c_lps) ? (c_levels - c_first) : c_lps);
      shift_stage #(
        .N_bits      (N_bits),
        .LEVELS      (c_nlev),
        .FIRST_LEVEL (c_first)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .en_i     (w_advance),
        .valid_i  (w_valid[s]),
        .data_i   (w_data[s]),
        .amount_i (w_amount[s]),
        .op_i     (w_op[s]),
        .fill_i   (w_fill[s]),
        .valid_o  (w_valid[s+1]),
        .data_o   (w_data[s+1]),
        .amount_o (w_amount[s+1]),
        .op_o     (w_op[s+1]),
        .fill_o   (w_fill[s+1]),
        .zero_o   (w_zero[s])
      );
    end
  endgenerate

  // Whole pipe moves when the output slot is free or being drained;
  // bubbles are deliberately not collapsed.
  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance;

  assign out_valid = w_valid[STAGES];
  assign out_d     = w_data[STAGES];
  assign out_zero  = w_zero[STAGES-1];

endmodule
`default_nettype wire
